// File: rtl/sync_fifo_dpram.sv
// rtl/sync_fifo_dpram.sv - single-clock FIFO on an inferred simple dual-port RAM (optional sticky errors: FIFO_ERR_STICKY_EN)
module sync_fifo_dpram #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
`ifdef FIFO_ERR_STICKY_EN
    output logic                       overflow,
    output logic                       underflow,
`endif
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             wr_acc, rd_acc;

    // Flags come straight from the registered count so they are glitch-free.
    assign full         = (count_q == FULL_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;

    // A read frees a slot in the same cycle, so a write at full is still
    // accepted when paired with a read; a read at empty is never accepted,
    // which also rules out any write-to-read bypass.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Next-state for pointers, occupancy and the read data register.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            dout_d       = mem[rd_ptr_q];
            dout_valid_d = 1'b1;
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers; reset empties the FIFO and kills any pending valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

`ifdef FIFO_ERR_STICKY_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Error flags latch on a dropped write or a read of an empty FIFO.
    always_comb begin
        overflow_d  = overflow_q  | (wr_en & full & ~rd_acc);
        underflow_d = underflow_q | (rd_en & empty);
    end

    // Sticky error registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_dpram.sv
// tb/tb_sync_fifo_dpram.sv - directed self-checking bench for sync_fifo_dpram
module tb_sync_fifo_dpram;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] din;
    logic        rd_en;
    logic [15:0] dout;
    logic        dout_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  count;
`ifdef FIFO_ERR_STICKY_EN
    logic        overflow;
    logic        underflow;
`endif

    int tests;
    int fails;

    sync_fifo_dpram #(
        .WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .din(din),
        .rd_en(rd_en),
        .dout(dout),
        .dout_valid(dout_valid),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
`ifdef FIFO_ERR_STICKY_EN
        .overflow(overflow),
        .underflow(underflow),
`endif
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge before checking.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset then idle
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_afull", almost_full, 0);
`ifdef FIFO_ERR_STICKY_EN
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
`endif

        // Fill 0..7, flags follow count
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            din   = 16'(i);
            step();
            chk($sformatf("fill_count%0d", i), count, i + 1);
            chk($sformatf("fill_aempty%0d", i), almost_empty, (i + 1 <= 2) ? 1 : 0);
            chk($sformatf("fill_afull%0d", i), almost_full, (i + 1 >= 6) ? 1 : 0);
            chk($sformatf("fill_full%0d", i), full, (i == 7) ? 1 : 0);
        end
        // 9th write dropped
        din = 16'h00FF;
        step();
        chk("drop_count", count, 8);
        chk("drop_full", full, 1);
`ifdef FIFO_ERR_STICKY_EN
        chk("drop_ovf", overflow, 1);
`endif
        wr_en = 1'b0;

        // Drain in order, one cycle latency
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            step();
            chk($sformatf("drain_valid%0d", i), dout_valid, 1);
            chk($sformatf("drain_dout%0d", i), dout, i);
            chk($sformatf("drain_count%0d", i), count, 7 - i);
        end
        chk("drain_empty", empty, 1);
        // Read at empty: ignored, dout holds
        step();
        chk("uread_valid", dout_valid, 0);
        chk("uread_dout", dout, 16'h0007);
        chk("uread_count", count, 0);
`ifdef FIFO_ERR_STICKY_EN
        chk("uread_udf", underflow, 1);
`endif
        rd_en = 1'b0;

        // Wrap: write 5, read 5, then 7 words across the wrap
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            din   = 16'(16'h0010 + i);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1;
            step();
            chk($sformatf("w5_dout%0d", i), dout, 16'h0010 + i);
        end
        rd_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1;
            din   = 16'(16'h00A0 + i);
            step();
        end
        wr_en = 1'b0;
        chk("wrap_count", count, 7);
        for (int i = 0; i < 7; i++) begin
            rd_en = 1'b1;
            step();
            chk($sformatf("wrap_valid%0d", i), dout_valid, 1);
            chk($sformatf("wrap_dout%0d", i), dout, 16'h00A0 + i);
        end
        rd_en = 1'b0;
        step();
        chk("wrap_empty", empty, 1);
        chk("wrap_idle_valid", dout_valid, 0);

        // Simultaneous read+write at full
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            din   = 16'(16'h0020 + i);
            step();
        end
        chk("sf_full", full, 1);
        rd_en = 1'b1;
        din   = 16'h1234;
        step();
        chk("sf_count", count, 8);
        chk("sf_valid", dout_valid, 1);
        chk("sf_dout", dout, 16'h0020);
        wr_en = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("sf_drain%0d", i), dout, 16'h0020 + i);
        end
        step();
        chk("sf_last", dout, 16'h1234);
        chk("sf_last_empty", empty, 1);

        // Simultaneous read+write at empty: read ignored, no bypass
        wr_en = 1'b1;
        din   = 16'h5555;
        step();
        chk("se_valid", dout_valid, 0);
        chk("se_count", count, 1);
        chk("se_empty", empty, 0);
        wr_en = 1'b0;
        step();
        chk("se_read_valid", dout_valid, 1);
        chk("se_read_dout", dout, 16'h5555);
        chk("se_read_count", count, 0);
        rd_en = 1'b0;

`ifdef FIFO_ERR_STICKY_EN
        chk("hold_ovf", overflow, 1);
        chk("hold_udf", underflow, 1);
`endif

        // Async reset mid-stream at count=4 with a valid in flight
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            din   = 16'(16'h0040 + i);
            step();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("pre_rst_count", count, 4);
        chk("pre_rst_valid", dout_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_valid", dout_valid, 0);
        chk("arst_dout", dout, 0);
`ifdef FIFO_ERR_STICKY_EN
        chk("arst_ovf", overflow, 0);
        chk("arst_udf", underflow, 0);
`endif
        #3;
        rst_n = 1'b1;
        step();
        chk("post_rst_empty", empty, 1);
        chk("post_rst_aempty", almost_empty, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
